// File: rtl/data_ram_responder_if.sv
// Core-side data-memory bus: one request per cycle, read data returned one cycle later.
interface data_ram_responder_if;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output mem_en, output mem_we, output addr, output wdata, input rdata);
    modport slave  (input mem_en, input mem_we, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_ram_responder.sv
// Data-memory responder: word-addressed RAM plus an MMIO page holding a cycle
// counter, tohost mailbox, GPIO register and sticky error status.
module data_ram_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic                 clk,
    input  logic                 rst,
    data_ram_responder_if.slave  bus,
    output logic [31:0]          tohost,
    output logic                 tohost_valid,
    output logic [7:0]           gpio_out,
    output logic                 err_misalign,
    output logic                 err_range
);

    localparam logic [7:0] OFF_CYCLE  = 8'h00;
    localparam logic [7:0] OFF_TOHOST = 8'h04;
    localparam logic [7:0] OFF_GPIO   = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;

    logic [31:0]       ram [DEPTH];
    logic [31:0]       cycle_cnt;
    logic [31:0]       rdata_q;
    logic [31:0]       rdata_next;
    logic [ADDR_W-1:0] word_idx;
    logic [7:0]        offset;
    logic              misaligned;
    logic              mmio_page;
    logic              mmio_hit;
    logic              ram_hit;
    logic              rd_req;
    logic              wr_req;
    logic              wr_ram;
    logic              wr_tohost;
    logic              wr_gpio;
    logic              clr_status;
    logic              set_misalign;
    logic              set_range;

    // NOTE: every signal gets a value before any branch so no latch can be inferred.
    always_comb begin
        word_idx     = bus.addr[ADDR_W+1:2];
        offset       = bus.addr[7:0];
        misaligned   = bus.addr[1:0] != 2'b00;
        mmio_page    = bus.addr[31:8] == MMIO_BASE[31:8];
        mmio_hit     = !misaligned && mmio_page &&
                       (offset inside {OFF_CYCLE, OFF_TOHOST, OFF_GPIO, OFF_STATUS});
        ram_hit      = !misaligned && !mmio_page && (bus.addr[31:ADDR_W+2] == '0);
        rd_req       = bus.mem_en && !bus.mem_we;
        wr_req       = bus.mem_en && bus.mem_we;
        wr_ram       = wr_req && ram_hit;
        wr_tohost    = wr_req && mmio_hit && (offset == OFF_TOHOST);
        wr_gpio      = wr_req && mmio_hit && (offset == OFF_GPIO);
        clr_status   = wr_req && mmio_hit && (offset == OFF_STATUS) && bus.wdata[0];
        set_misalign = bus.mem_en && misaligned;
        set_range    = bus.mem_en && !misaligned && !mmio_hit && !ram_hit;

        // Failed accesses read as zero; idle cycles hold the previous result.
        rdata_next = rdata_q;
        if (rd_req) begin
            rdata_next = '0;
            if (ram_hit) begin
                rdata_next = ram[word_idx];
            end else if (mmio_hit) begin
                case (offset)
                    OFF_CYCLE:  rdata_next = cycle_cnt;
                    OFF_TOHOST: rdata_next = tohost;
                    OFF_GPIO:   rdata_next = {24'b0, gpio_out};
                    OFF_STATUS: rdata_next = {30'b0, err_range, err_misalign};
                    default:    rdata_next = '0;
                endcase
            end
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt    <= '0;
            rdata_q      <= '0;
            tohost       <= '0;
            tohost_valid <= 1'b0;
            gpio_out     <= '0;
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            cycle_cnt    <= cycle_cnt + 32'd1;
            rdata_q      <= rdata_next;
            tohost_valid <= wr_tohost;
            if (wr_tohost) tohost   <= bus.wdata;
            if (wr_gpio)   gpio_out <= bus.wdata[7:0];
            if (clr_status) begin
                err_misalign <= 1'b0;
                err_range    <= 1'b0;
            end else begin
                if (set_misalign) err_misalign <= 1'b1;
                if (set_range)    err_range    <= 1'b1;
            end
        end
    end

    // NOTE: RAM contents are deliberately not reset; rst only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && wr_ram) ram[word_idx] <= bus.wdata;
    end

    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench for data_ram_responder: read expectations are queued at
// request time and compared when the registered read data appears.
module tb_data_ram_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] CYCLE_A  = 32'hFFFF_FF00;
    localparam logic [31:0] TOHOST_A = 32'hFFFF_FF04;
    localparam logic [31:0] GPIO_A   = 32'hFFFF_FF08;
    localparam logic [31:0] STATUS_A = 32'hFFFF_FF0C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tohost;
    logic        tohost_valid;
    logic [7:0]  gpio_out;
    logic        err_misalign;
    logic        err_range;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];
    logic [31:0] ram_model [int unsigned];
    logic [31:0] model_cyc;

    data_ram_responder_if bus ();

    data_ram_responder #(.DEPTH(DEPTH), .ADDR_W(10), .MMIO_BASE(32'hFFFF_FF00)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .tohost       (tohost),
        .tohost_valid (tohost_valid),
        .gpio_out     (gpio_out),
        .err_misalign (err_misalign),
        .err_range    (err_range)
    );

    always #5 clk = ~clk;

    // Reference cycle counter: value seen by a request issued in the current cycle.
    always @(posedge clk) model_cyc <= rst ? 32'd0 : model_cyc + 32'd1;

    // One bus cycle: drive, wait past the edge, then score any completed read.
    task automatic access(input logic en, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp, input string nm);
        logic [31:0] e;
        string       n;
        bus.mem_en = en;
        bus.mem_we = we;
        bus.addr   = a;
        bus.wdata  = d;
        if (en && !we) begin
            exp_q.push_back(exp);
            name_q.push_back(nm);
        end
        @(posedge clk);
        #1;
        bus.mem_en = 1'b0;
        bus.mem_we = 1'b0;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (bus.rdata !== e) begin
                failures++;
                $display("FAIL %s: rdata=%h expected=%h", n, bus.rdata, e);
            end
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        access(1'b1, 1'b1, a, d, 32'd0, "");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        access(1'b1, 1'b0, a, 32'd0, exp, nm);
    endtask

    task automatic idle();
        access(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, "");
    endtask

    task automatic ram_wr(input logic [31:0] a, input logic [31:0] d);
        wr(a, d);
        ram_model[a] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_en = 1'b0; bus.mem_we = 1'b0; bus.addr = '0; bus.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata: got=%h want=0", bus.rdata); end
        checks++; if (tohost !== 32'd0) begin failures++; $display("FAIL reset_tohost: got=%h want=0", tohost); end
        checks++; if ({tohost_valid, gpio_out, err_misalign, err_range} !== 11'd0) begin
            failures++; $display("FAIL reset_flags: got=%b want=0", {tohost_valid, gpio_out, err_misalign, err_range});
        end
        rst = 1'b0;
        repeat (5) idle();
        rd(CYCLE_A, 32'd5, "cycle_after_5_idle");
        rd(CYCLE_A, model_cyc, "cycle_next");
        wr(CYCLE_A, 32'h1234_5678);
        checks++; if ({err_misalign, err_range} !== 2'b00) begin failures++; $display("FAIL cycle_write_err: got=%b want=00", {err_misalign, err_range}); end
        rd(CYCLE_A, model_cyc, "cycle_after_write");
    endtask

    task automatic test_ram();
        ram_wr(32'h0000_0000, 32'h0BAD_F00D);
        ram_wr(32'h0000_0014, 32'h1234_5678);
        ram_wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_read_after_write");
        rd(32'h0000_0014, 32'h1234_5678, "ram_neighbour");
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_intact");
        idle();
        checks++; if (bus.rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rdata_hold: got=%h want=deadbeef", bus.rdata); end
        ram_wr(4 * DEPTH - 4, 32'hCAFE_0001);
        for (int i = 0; i < 12; i++) ram_wr($urandom_range(1, DEPTH - 2) * 4, $urandom);
        foreach (ram_model[k]) rd(k, ram_model[k], "ram_scoreboard");
    endtask

    task automatic test_tohost();
        wr(TOHOST_A, 32'd1);
        checks++; if (tohost !== 32'd1 || tohost_valid !== 1'b1) begin failures++; $display("FAIL tohost_first: got=%h/%b want=1/1", tohost, tohost_valid); end
        idle();
        checks++; if (tohost_valid !== 1'b0) begin failures++; $display("FAIL tohost_pulse_end: got=%b want=0", tohost_valid); end
        wr(TOHOST_A, 32'd2);
        checks++; if (tohost !== 32'd2 || tohost_valid !== 1'b1) begin failures++; $display("FAIL tohost_b2b_1: got=%h/%b want=2/1", tohost, tohost_valid); end
        wr(TOHOST_A, 32'd3);
        checks++; if (tohost !== 32'd3 || tohost_valid !== 1'b1) begin failures++; $display("FAIL tohost_b2b_2: got=%h/%b want=3/1", tohost, tohost_valid); end
        rd(TOHOST_A, 32'd3, "tohost_read");
        checks++; if (tohost_valid !== 1'b0) begin failures++; $display("FAIL tohost_b2b_end: got=%b want=0", tohost_valid); end
    endtask

    task automatic test_gpio();
        wr(GPIO_A, 32'hA5A5_A55A);
        checks++; if (gpio_out !== 8'h5A) begin failures++; $display("FAIL gpio_out: got=%h want=5a", gpio_out); end
        rd(GPIO_A, 32'h0000_005A, "gpio_read");
    endtask

    task automatic test_errors();
        rd(32'h0000_0002, 32'd0, "misaligned_read");
        checks++; if ({err_misalign, err_range} !== 2'b10) begin failures++; $display("FAIL misalign_flag: got=%b want=10", {err_misalign, err_range}); end
        wr(32'h0000_0012, 32'h5555_5555);
        rd(32'h0000_0010, 32'hDEAD_BEEF, "misaligned_write_dropped");
        wr(4 * DEPTH, 32'h7777_7777);
        checks++; if ({err_misalign, err_range} !== 2'b11) begin failures++; $display("FAIL range_flag: got=%b want=11", {err_misalign, err_range}); end
        rd(32'h0000_0000, 32'h0BAD_F00D, "range_write_dropped");
        rd(STATUS_A, 32'h0000_0003, "status_both");
        wr(STATUS_A, 32'h0000_0000);
        checks++; if ({err_misalign, err_range} !== 2'b11) begin failures++; $display("FAIL status_noclear: got=%b want=11", {err_misalign, err_range}); end
        wr(STATUS_A, 32'h0000_0001);
        checks++; if ({err_misalign, err_range} !== 2'b00) begin failures++; $display("FAIL status_clear: got=%b want=00", {err_misalign, err_range}); end
        rd(32'hFFFF_FF10, 32'd0, "mmio_undefined_read");
        checks++; if ({err_misalign, err_range} !== 2'b01) begin failures++; $display("FAIL mmio_undefined_flag: got=%b want=01", {err_misalign, err_range}); end
        rd(STATUS_A, 32'h0000_0002, "status_range_only");
        wr(STATUS_A, 32'h0000_0001);
        access(1'b0, 1'b1, 32'h0000_0010, 32'h9999_9999, 32'd0, "");
        checks++; if ({err_misalign, err_range} !== 2'b00 || bus.rdata !== 32'h0000_0002) begin
            failures++; $display("FAIL we_without_en: got=%b/%h want=00/00000002", {err_misalign, err_range}, bus.rdata);
        end
        rd(32'h0000_0010, 32'hDEAD_BEEF, "we_without_en_ram");
    endtask

    task automatic test_reset_write();
        ram_wr(32'h0000_0020, 32'hAAAA_0001);
        rd(32'h0000_0020, 32'hAAAA_0001, "pre_reset_read");
        wr(TOHOST_A, 32'd7);
        rst = 1'b1;
        wr(32'h0000_0020, 32'hBBBB_0002);
        checks++; if (bus.rdata !== 32'd0 || tohost !== 32'd0) begin failures++; $display("FAIL reset_wins_data: got=%h/%h want=0/0", bus.rdata, tohost); end
        checks++; if ({tohost_valid, gpio_out, err_misalign, err_range} !== 11'd0) begin
            failures++; $display("FAIL reset_wins_flags: got=%b want=0", {tohost_valid, gpio_out, err_misalign, err_range});
        end
        rst = 1'b0;
        rd(32'h0000_0020, 32'hAAAA_0001, "reset_dropped_write");
        rd(CYCLE_A, model_cyc, "cycle_after_reset2");
    endtask

    initial begin
        test_reset();
        test_ram();
        test_tohost();
        test_gpio();
        test_errors();
        test_reset_write();
        idle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Responder side of the core's data-memory port.
- Accepts the core's M-stage requests (enable, write-enable, address, write data) and returns read data one cycle later.
- Backs a word-addressed synchronous RAM plus a small MMIO page: free-running cycle counter, tohost mailbox, GPIO register, and sticky error status.
- Sits beside the core at SoC top level and replaces a bare block-RAM instance.

Parameters:
- DEPTH, 1024, number of 32-bit RAM words; power of two.
- ADDR_W, 10, log2(DEPTH); RAM word index = addr[ADDR_W+1:2].
- MMIO_BASE, 32'hFFFF_FF00, base of the 256-byte MMIO page.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_en  in  1  request valid (core data_ram_ena_M).
- mem_we  in  1  write when mem_en=1 (core data_ram_wea_M); ignored when mem_en=0.
- addr  in  32  byte address (core alu_result_M).
- wdata  in  32  write data (core mem_wdata_M).
- rdata  out  32  registered read data (to core mem_rdata_M).
- tohost  out  32  last value written to TOHOST.
- tohost_valid  out  1  one-cycle pulse per TOHOST write.
- gpio_out  out  8  GPIO register.
- err_misalign  out  1  sticky: access with addr[1:0]!=0.
- err_range  out  1  sticky: access outside RAM and outside defined MMIO offsets.

Behaviour:
- Reset (rst=1 at an edge):
  - rdata, tohost, gpio_out, cycle counter = 0; tohost_valid, err_misalign, err_range = 0.
  - RAM contents are not reset.
  - Reset wins over any same-cycle request: the request is dropped and RAM is not written.
- Single-port operation: at most one access per cycle; no queueing, no backpressure, no stall output.
- Decode priority: misaligned, then MMIO (addr[31:8]==MMIO_BASE[31:8]), then RAM (addr < 4*DEPTH), else range error.
- Read latency 1:
  - When mem_en=1 and mem_we=0 in cycle N, rdata holds the result from cycle N+1.
  - rdata holds its value in cycles with no read.
- Write: when mem_en=1 and mem_we=1 in cycle N, the target updates at the end of cycle N. A read at N+1 returns the new value (no read-before-write hazard across cycles).
- Misaligned access: set err_misalign; drop the write; a read returns 0.
- Out-of-range access: set err_range; drop the write; a read returns 0.
- MMIO offsets:
  - 0x00 CYCLE, read-only.
    - 32-bit counter increments every non-reset cycle and wraps FFFF_FFFF to 0.
    - A read returns the counter value in the request cycle.
    - Writes are ignored with no error.
  - 0x04 TOHOST.
    - Write: tohost <= wdata; tohost_valid=1 for the following cycle only.
    - Back-to-back writes give consecutive pulses.
    - Read returns tohost.
  - 0x08 GPIO.
    - Write: gpio_out <= wdata[7:0].
    - Read returns {24'b0, gpio_out}.
  - 0x0C STATUS.
    - Read returns {30'b0, err_range, err_misalign}.
    - Write with wdata[0]=1 clears both error flags; wdata[0]=0 has no effect.
  - Any other MMIO offset is treated as out-of-range.
- Error flags are sticky until a STATUS clear or reset. A clearing access is itself valid, so no error can set in the same cycle.
- mem_we=1 with mem_en=0 has no effect: no write, no error, rdata held.

Test Plan:
- Reset then idle for 5 cycles; read CYCLE -> rdata=5 the next cycle (counter value in the request cycle); all other outputs 0.
- Write 32'hDEADBEEF to 0x0000_0010, read 0x10 in the next cycle -> rdata=DEADBEEF one cycle after the read; a read of 0x14 in between leaves 0x10 intact.
- Write 32'h1 to 0xFFFF_FF04 -> tohost=1 and tohost_valid high exactly one cycle; two back-to-back writes (2, 3) -> two pulses, tohost=3.
- Write 0xA5A5_A55A to 0xFFFF_FF08 -> gpio_out=8'h5A; read back -> rdata=32'h0000_005A.
- Read 0x0000_0002 -> err_misalign=1, rdata=0. Write 4*DEPTH -> err_range=1, RAM unchanged. Read STATUS -> 32'h3. Write STATUS with 1 -> flags 0.
- Assert rst in the same cycle as a RAM write -> the location keeps its prior value and all outputs return to reset values next cycle.
